cr16_fib_sequencer: RTL
=======================

// Module: cr16_fib_sequencer
// PURPOSE
//   Control-side driver for cr16_datapath: generates the register-enable, opcode, read-select and immediate bus.
//   Runs a self-checking Fibonacci program: clears r2..r15, seeds r0 = r1 = 1, then computes r(k+2) = r(k) + r(k+1).
//   Checks every ALU result against an internal shadow model and reports done, first error and last value.
//   Sits between a top-level start/status interface and the datapath control inputs; it is the bring-up
//   sequencer for the datapath on hardware.
// PARAMETERS
//   DATA_WIDTH  16       datapath word width
//   NUM_REGS    16       register-file depth; one-hot O_REG_ENABLE width
//   ADD_OPCODE  4'b0000  datapath opcode for ADD
// PORTS
//   I_CLK              in   1   clock, rising edge
//   I_NRESET           in   1   asynchronous, active-low reset
//   I_ENABLE           in   1   global enable; low = freeze
//   I_START            in   1   start request, sampled in IDLE/DONE
//   I_WRITE_PORT       in   16  datapath ALU/write-port result (combinational from current controls)
//   I_FLAGS            in   5   datapath flags (captured only, not checked)
//   O_REG_ENABLE       out  16  one-hot register write enable
//   O_OPCODE           out  4   datapath opcode
//   O_READ_PORT_A_SEL  out  4   read port A register index
//   O_READ_PORT_B_SEL  out  4   read port B register index
//   O_IMMEDIATE        out  16  immediate value
//   O_IMM_SEL          out  1   1 = write immediate, 0 = write ALU result
//   O_BUSY             out  1   program in progress
//   O_DONE             out  1   program complete (level, held until next start)
//   O_ERROR            out  1   sticky mismatch flag
//   O_ERR_INDEX        out  4   destination register of first mismatch
//   O_LAST_VALUE       out  16  last ALU result checked
//   O_LAST_FLAGS       out  5   I_FLAGS at last check
// BEHAVIOUR
//   Reset
//   - One clock (I_CLK); reset I_NRESET is asynchronous, active-low.
//   - On reset, all outputs are 0 and the FSM is in IDLE; this also applies mid-program.
//   Timing and enable
//   - All outputs are registered. Controls are presented for one cycle, and the datapath commits on the
//     following rising edge.
//   - I_ENABLE low: FSM, counters and shadow are frozen; O_REG_ENABLE is forced to 0; other outputs hold.
//     Resume continues exactly where it stopped.
//   FSM: IDLE -> CLEAR -> SEED0 -> SEED1 -> RUN -> DONE
//   - IDLE: all controls 0. I_START=1 -> CLEAR; clears O_DONE, O_ERROR, O_ERR_INDEX, O_LAST_VALUE; O_BUSY=1.
//   - CLEAR: 14 cycles, O_IMM_SEL=1, O_IMMEDIATE=0, O_REG_ENABLE walks 1<<2 .. 1<<15.
//   - SEED0: 1 cycle, O_IMM_SEL=1, O_IMMEDIATE=1, O_REG_ENABLE=1<<0.
//   - SEED1: 1 cycle, O_IMM_SEL=1, O_IMMEDIATE=1, O_REG_ENABLE=1<<1. Shadow prev=1, cur=1.
//   - RUN: k=0..13, 14 cycles.
//     - Controls: O_IMM_SEL=0, O_OPCODE=ADD_OPCODE, A_SEL=k, B_SEL=k+1, O_REG_ENABLE=1<<(k+2).
//     - Check on the committing edge: expected = (prev+cur) mod 2^16.
//     - On mismatch with O_ERROR=0: set O_ERROR, O_ERR_INDEX=k+2.
//     - Always load O_LAST_VALUE=I_WRITE_PORT and O_LAST_FLAGS=I_FLAGS.
//     - Shadow advances from the expected value, not the observed one: prev<=cur, cur<=expected.
//     - After k=13 -> DONE.
//   - DONE: controls 0, O_BUSY=0, O_DONE=1. I_START -> CLEAR (restart, status cleared as in IDLE).
//   - Busy from start to done: 1 + 14 + 2 + 14 = 31 enabled cycles; O_DONE rises on cycle 31.
//   Boundary conditions
//   - I_START while busy is ignored.
//   - I_START and I_ENABLE=0 together are ignored.
//   - Index arithmetic never wraps, since k+2 <= 15.
// TESTING
//   - Reset, pulse I_START, bench datapath model -> O_DONE after 31 cycles; O_LAST_VALUE=987; O_ERROR=0;
//     r2..r15 = 2,3,5,...,610,987.
//   - Model corrupts the r7 write (21 -> 22) -> O_ERROR=1, O_ERR_INDEX=7; later checks still use the shadow
//     model; O_DONE at cycle 31; O_LAST_VALUE=987.
//   - I_ENABLE low 5 cycles at RUN k=4 -> O_REG_ENABLE=0 throughout; no state change; O_DONE at cycle 36;
//     results identical.
//   - I_NRESET low mid-CLEAR -> all outputs 0 immediately (no clock edge needed); restart completes with 987.
//   - I_START at RUN k=3 ignored; I_START in DONE -> O_DONE and O_ERROR clear next cycle; O_BUSY=1;
//     second run passes.

Source files
------------

// File: rtl/cr16_fib_sequencer.sv
// -----------------------------------------------------------------------------
// cr16_fib_sequencer
//
// Bring-up sequencer for cr16_datapath. It drives the datapath control inputs
// through a fixed self-checking Fibonacci program:
//   1. clear r2..r15 with an immediate 0,
//   2. seed r0 = r1 = 1 with immediates,
//   3. compute r(k+2) = r(k) + r(k+1) for k = 0..13 using the datapath ADD.
// Every ALU result is compared with an internal shadow of the sequence.
// Status reports completion, the first mismatching destination and the last
// checked value/flags.
//
// Ports
//   I_CLK              in   clock, rising edge
//   I_NRESET           in   asynchronous active-low reset
//   I_ENABLE           in   global enable; low freezes the sequencer
//   I_START            in   start request, honoured only in IDLE/DONE
//   I_WRITE_PORT       in   datapath write-port value for the presented controls
//   I_FLAGS            in   datapath flags, captured alongside each check
//   O_REG_ENABLE       out  one-hot register write enable (0 while frozen)
//   O_OPCODE           out  datapath opcode
//   O_READ_PORT_A_SEL  out  read port A register index
//   O_READ_PORT_B_SEL  out  read port B register index
//   O_IMMEDIATE        out  immediate value
//   O_IMM_SEL          out  1 = write immediate, 0 = write ALU result
//   O_BUSY             out  program in progress
//   O_DONE             out  program complete, held until the next start
//   O_ERROR            out  sticky mismatch flag
//   O_ERR_INDEX        out  destination register of the first mismatch
//   O_LAST_VALUE       out  last ALU result checked
//   O_LAST_FLAGS       out  I_FLAGS sampled at the last check
// -----------------------------------------------------------------------------
module cr16_fib_sequencer #(
    parameter int         DATA_WIDTH = 16,
    parameter int         NUM_REGS   = 16,
    parameter logic [3:0] ADD_OPCODE = 4'b0000
) (
    input  logic                        I_CLK,
    input  logic                        I_NRESET,
    input  logic                        I_ENABLE,
    input  logic                        I_START,
    input  logic [DATA_WIDTH-1:0]       I_WRITE_PORT,
    input  logic [4:0]                  I_FLAGS,
    output logic [NUM_REGS-1:0]         O_REG_ENABLE,
    output logic [3:0]                  O_OPCODE,
    output logic [$clog2(NUM_REGS)-1:0] O_READ_PORT_A_SEL,
    output logic [$clog2(NUM_REGS)-1:0] O_READ_PORT_B_SEL,
    output logic [DATA_WIDTH-1:0]       O_IMMEDIATE,
    output logic                        O_IMM_SEL,
    output logic                        O_BUSY,
    output logic                        O_DONE,
    output logic                        O_ERROR,
    output logic [$clog2(NUM_REGS)-1:0] O_ERR_INDEX,
    output logic [DATA_WIDTH-1:0]       O_LAST_VALUE,
    output logic [4:0]                  O_LAST_FLAGS
);

    localparam int IDX_W = $clog2(NUM_REGS);

    // Both CLEAR and RUN walk the destinations r2..r(NUM_REGS-1).
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NUM_REGS - 3);
    localparam logic [IDX_W-1:0] DEST_BASE = IDX_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SEED0 = 3'd2,
        ST_SEED1 = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_reg;
    state_t                 state_next;
    logic [IDX_W-1:0]       step_reg;
    logic [IDX_W-1:0]       step_next;

    // Registered controls and status
    logic [NUM_REGS-1:0]    reg_enable_reg;
    logic [3:0]             opcode_reg;
    logic [IDX_W-1:0]       a_sel_reg;
    logic [IDX_W-1:0]       b_sel_reg;
    logic [DATA_WIDTH-1:0]  immediate_reg;
    logic                   imm_sel_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   error_reg;
    logic [IDX_W-1:0]       err_index_reg;
    logic [DATA_WIDTH-1:0]  last_value_reg;
    logic [4:0]             last_flags_reg;

    // Shadow of the two most recent sequence terms
    logic [DATA_WIDTH-1:0]  prev_reg;
    logic [DATA_WIDTH-1:0]  cur_reg;

    // Controls for the state being entered
    logic                   dest_valid_next;
    logic [IDX_W-1:0]       dest_next;
    logic [NUM_REGS-1:0]    reg_enable_next;
    logic [3:0]             opcode_next;
    logic [IDX_W-1:0]       a_sel_next;
    logic [IDX_W-1:0]       b_sel_next;
    logic [DATA_WIDTH-1:0]  immediate_next;
    logic                   imm_sel_next;
    logic                   busy_next;
    logic                   done_next;

    // Check path
    logic                   start_accept;
    logic                   run_commit;
    logic [DATA_WIDTH-1:0]  expected_sum;
    logic                   mismatch;
    logic [IDX_W-1:0]       run_dest;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        if (I_ENABLE) begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (I_START) begin
                        state_next = ST_CLEAR;
                        step_next  = '0;
                    end
                end
                ST_CLEAR: begin
                    if (step_reg == LAST_STEP) begin
                        state_next = ST_SEED0;
                        step_next  = '0;
                    end else begin
                        step_next = step_reg + IDX_W'(1);
                    end
                end
                ST_SEED0: begin
                    state_next = ST_SEED1;
                end
                ST_SEED1: begin
                    state_next = ST_RUN;
                    step_next  = '0;
                end
                ST_RUN: begin
                    if (step_reg == LAST_STEP) begin
                        state_next = ST_DONE;
                        step_next  = '0;
                    end else begin
                        step_next = step_reg + IDX_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    step_next  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control decode for the state being entered. Outputs are registered, so
    // the decode looks at state_next/step_next rather than the current state.
    // -------------------------------------------------------------------------
    always_comb begin
        dest_valid_next = 1'b0;
        dest_next       = '0;
        opcode_next     = '0;
        a_sel_next      = '0;
        b_sel_next      = '0;
        immediate_next  = '0;
        imm_sel_next    = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        case (state_next)
            ST_CLEAR: begin
                dest_valid_next = 1'b1;
                dest_next       = step_next + DEST_BASE;
                imm_sel_next    = 1'b1;
                busy_next       = 1'b1;
            end
            ST_SEED0: begin
                dest_valid_next = 1'b1;
                dest_next       = IDX_W'(0);
                imm_sel_next    = 1'b1;
                immediate_next  = DATA_WIDTH'(1);
                busy_next       = 1'b1;
            end
            ST_SEED1: begin
                dest_valid_next = 1'b1;
                dest_next       = IDX_W'(1);
                imm_sel_next    = 1'b1;
                immediate_next  = DATA_WIDTH'(1);
                busy_next       = 1'b1;
            end
            ST_RUN: begin
                dest_valid_next = 1'b1;
                dest_next       = step_next + DEST_BASE;
                opcode_next     = ADD_OPCODE;
                a_sel_next      = step_next;
                b_sel_next      = step_next + IDX_W'(1);
                busy_next       = 1'b1;
            end
            ST_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // One-hot write-enable decode of the destination index.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
            assign reg_enable_next[gi] = dest_valid_next && (dest_next == IDX_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Result check. The RUN controls currently on the outputs are committed by
    // the datapath on this edge, so I_WRITE_PORT is compared now.
    // -------------------------------------------------------------------------
    assign start_accept = I_ENABLE && I_START &&
                          ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign run_commit   = I_ENABLE && (state_reg == ST_RUN);
    assign expected_sum = prev_reg + cur_reg;   // wraps mod 2^DATA_WIDTH
    assign mismatch     = (I_WRITE_PORT != expected_sum);
    assign run_dest     = step_reg + DEST_BASE;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_reg      <= ST_IDLE;
            step_reg       <= '0;
            reg_enable_reg <= '0;
            opcode_reg     <= '0;
            a_sel_reg      <= '0;
            b_sel_reg      <= '0;
            immediate_reg  <= '0;
            imm_sel_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            err_index_reg  <= '0;
            last_value_reg <= '0;
            last_flags_reg <= '0;
            prev_reg       <= '0;
            cur_reg        <= '0;
        end else if (I_ENABLE) begin
            state_reg      <= state_next;
            step_reg       <= step_next;
            reg_enable_reg <= reg_enable_next;
            opcode_reg     <= opcode_next;
            a_sel_reg      <= a_sel_next;
            b_sel_reg      <= b_sel_next;
            immediate_reg  <= immediate_next;
            imm_sel_reg    <= imm_sel_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;

            if (start_accept) begin
                error_reg      <= 1'b0;
                err_index_reg  <= '0;
                last_value_reg <= '0;
            end else if (run_commit) begin
                if (mismatch && !error_reg) begin
                    error_reg     <= 1'b1;
                    err_index_reg <= run_dest;
                end
                last_value_reg <= I_WRITE_PORT;
                last_flags_reg <= I_FLAGS;
            end

            // The shadow advances from the expected value so that one bad
            // result does not cascade into every later comparison.
            if (state_reg == ST_SEED1) begin
                prev_reg <= DATA_WIDTH'(1);
                cur_reg  <= DATA_WIDTH'(1);
            end else if (state_reg == ST_RUN) begin
                prev_reg <= cur_reg;
                cur_reg  <= expected_sum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The write enable is gated by I_ENABLE so that a frozen cycle
    // never commits anything in the datapath; on resume the held controls are
    // re-presented and committed exactly once.
    // -------------------------------------------------------------------------
    assign O_REG_ENABLE      = reg_enable_reg & {NUM_REGS{I_ENABLE}};
    assign O_OPCODE          = opcode_reg;
    assign O_READ_PORT_A_SEL = a_sel_reg;
    assign O_READ_PORT_B_SEL = b_sel_reg;
    assign O_IMMEDIATE       = immediate_reg;
    assign O_IMM_SEL         = imm_sel_reg;
    assign O_BUSY            = busy_reg;
    assign O_DONE            = done_reg;
    assign O_ERROR           = error_reg;
    assign O_ERR_INDEX       = err_index_reg;
    assign O_LAST_VALUE      = last_value_reg;
    assign O_LAST_FLAGS      = last_flags_reg;

endmodule
